polyz_pack_stream: RTL and testbench

- Streaming, parametrised successor to the combinational z-vector packer.
- Accepts one signed 32-bit coefficient per handshake and maps it to t = GAMMA1 - a.
- Packs t little-endian into a bit accumulator and emits OUT_BYTES-wide words on a valid/ready stream.
- Supports both Dilithium z encodings, selected per polynomial: GAMMA1 = 2^17 (18-bit, 576 bytes) and GAMMA1 = 2^19 (20-bit, 640 bytes). Sits between the signing datapath and the signature byte buffer.

---
 rtl/dilithium_pkg.sv | 12 +
 rtl/polyz_coeff_map.sv | 15 +
 rtl/polyz_pack_stream.sv | 113 +++++++++++
 tb/tb_polyz_pack_stream.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - shared Dilithium constants for the z-vector packer
package dilithium_pkg;
   localparam int N = 256;
   localparam logic [31:0] GAMMA1_17 = 32'h0002_0000;
   localparam logic [31:0] GAMMA1_19 = 32'h0008_0000;
   localparam int ZW_17 = 18;
   localparam int ZW_19 = 20;

   function automatic logic [31:0] gamma1_of(input logic sel);
      return sel ? GAMMA1_19 : GAMMA1_17;
   endfunction
endpackage

// File: rtl/polyz_coeff_map.sv
// rtl/polyz_coeff_map.sv - maps coefficient a to t = GAMMA1 - a, truncated to ZW bits
import dilithium_pkg::*;

module polyz_coeff_map (
   input  logic [31:0] a,
   input  logic        sel,
   output logic [19:0] t
);
   logic [31:0] diff;

   always_comb begin
      diff = gamma1_of(sel) - a;
      t    = sel ? diff[19:0] : {2'b00, diff[17:0]};
   end
endmodule

// File: rtl/polyz_pack_stream.sv
// rtl/polyz_pack_stream.sv - streaming z-polynomial bit packer with valid/ready ports
import dilithium_pkg::*;

module polyz_pack_stream #(
   parameter int N         = 256,
   parameter int OUT_BYTES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   gamma1_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_coeff,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*OUT_BYTES-1:0] out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
);
   localparam int OW    = 8 * OUT_BYTES;
   localparam int BUF_W = OW + 32;
   localparam int CW    = $clog2(BUF_W + 1);
   localparam int NW    = $clog2(N + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PACK  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state;
   logic [BUF_W-1:0] acc_buf;
   logic [CW-1:0]    cnt;
   logic [NW-1:0]    ccnt;
   logic             mode;
   logic             done_r;

   logic [19:0]      t;
   logic [CW-1:0]    zw;
   logic             accept;
   logic             emit;
   logic [BUF_W-1:0] base_buf;
   logic [CW-1:0]    base_cnt;
   logic [BUF_W-1:0] ins;

   polyz_coeff_map u_map (
      .a   (in_coeff),
      .sel (mode),
      .t   (t)
   );

   assign zw        = mode ? CW'(ZW_19) : CW'(ZW_17);
   assign in_ready  = (state == S_PACK) && (cnt <= CW'(BUF_W) - zw);
   assign out_valid = (state != S_IDLE) && (cnt >= CW'(OW));
   assign out_data  = acc_buf[OW-1:0];
   assign out_last  = out_valid && (state == S_DRAIN) && (cnt == CW'(OW));
   assign busy      = (state != S_IDLE);
   assign done      = done_r;
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   // The new coefficient lands just above whatever survives this cycle's shift-out.
   always_comb begin
      base_buf = emit ? (acc_buf >> OW) : acc_buf;
      base_cnt = emit ? (cnt - CW'(OW)) : cnt;
      ins      = accept ? (BUF_W'(t) << base_cnt) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         acc_buf <= '0;
         cnt     <= '0;
         ccnt    <= '0;
         mode    <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !done_r) begin
                  state   <= S_PACK;
                  mode    <= gamma1_sel;
                  acc_buf <= '0;
                  cnt     <= '0;
                  ccnt    <= '0;
               end
            end
            S_PACK: begin
               acc_buf <= base_buf | ins;
               cnt     <= base_cnt + (accept ? zw : CW'(0));
               if (accept) begin
                  ccnt <= ccnt + NW'(1);
                  if (ccnt == NW'(N - 1))
                     state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               acc_buf <= base_buf;
               cnt     <= base_cnt;
               if (emit && out_last) begin
                  state  <= S_IDLE;
                  done_r <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Every legal polynomial is a whole number of output words.
   assert property (@(posedge clk) disable iff (rst) (emit && out_last) |=> (cnt == '0));
endmodule

// File: tb/tb_polyz_pack_stream.sv
// tb/tb_polyz_pack_stream.sv - scoreboard bench for polyz_pack_stream at OUT_BYTES 1 and 4
module tb_polyz_pack_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start1, start4, gamma1_sel, in_valid, out_ready;
   logic [31:0] in_coeff;
   logic        in_ready1, out_valid1, out_last1, busy1, done1;
   logic [7:0]  out_data1;
   logic        in_ready4, out_valid4, out_last4, busy4, done4;
   logic [31:0] out_data4;

   polyz_pack_stream #(.N(256), .OUT_BYTES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .gamma1_sel(gamma1_sel),
      .in_valid(in_valid), .in_ready(in_ready1), .in_coeff(in_coeff),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_last(out_last1), .busy(busy1), .done(done1)
   );

   polyz_pack_stream #(.N(256), .OUT_BYTES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .gamma1_sel(gamma1_sel),
      .in_valid(in_valid), .in_ready(in_ready4), .in_coeff(in_coeff),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .out_last(out_last4), .busy(busy4), .done(done4)
   );

   logic        use4;
   logic        o_ready, o_valid, o_last, o_busy, o_done;
   logic [31:0] o_data;

   always_comb begin
      o_ready = use4 ? in_ready4  : in_ready1;
      o_valid = use4 ? out_valid4 : out_valid1;
      o_last  = use4 ? out_last4  : out_last1;
      o_busy  = use4 ? busy4      : busy1;
      o_done  = use4 ? done4      : done1;
      o_data  = use4 ? out_data4  : {24'h0, out_data1};
   end

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] coeffs[256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_in_ready"}, o_ready, 0);
      check({tag, "_out_valid"}, o_valid, 0);
      check({tag, "_out_data"}, o_data, 0);
      check({tag, "_out_last"}, o_last, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
   endtask

   task automatic pattern_exp(input logic [71:0] pat, input int plen, input int total);
      exp_q.delete();
      for (int i = 0; i < total; i++)
         exp_q.push_back(pat[8*(i % plen) +: 8]);
   endtask

   // Software pack_z: append ZW bits of t per coefficient, emit bytes LSB first.
   task automatic model_exp(input bit sel);
      longint unsigned acc = 0;
      int              nb = 0;
      int              zw = sel ? 20 : 18;
      logic [31:0]     g  = sel ? 32'h0008_0000 : 32'h0002_0000;
      logic [31:0]     t;
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         t = (g - coeffs[i]) & ((32'h1 << zw) - 32'h1);
         acc = acc | (longint'(t) << nb);
         nb += zw;
         while (nb >= 8) begin
            exp_q.push_back(acc[7:0]);
            acc = acc >> 8;
            nb -= 8;
         end
      end
   endtask

   task automatic rand_coeffs(input bit sel);
      int g = sel ? 524288 : 131072;
      for (int i = 0; i < 256; i++)
         coeffs[i] = int'($urandom_range(0, 2 * g - 1)) - g + 1;
      coeffs[0] = g;
      coeffs[1] = -g + 1;
   endtask

   task automatic run_poly(input bit u4, input bit sel, input int pct, input int abort_at,
                           input bit poke, input bit start_on_done);
      int          ob    = u4 ? 4 : 1;
      int          ow    = 8 * ob;
      int          bufw  = ow + 32;
      int          zw    = sel ? 20 : 18;
      int          total = exp_q.size();
      int          nacc  = 0;
      int          nbytes = 0;
      int          mcnt  = 0;
      int          cyc   = 0;
      bit          stall_pend = 0;
      bit          done_pend  = 0;
      logic [31:0] stall_data = '0;
      logic [31:0] w;
      use4 = u4;
      @(negedge clk);
      gamma1_sel = sel;
      start1 = !u4;
      start4 = u4;
      @(negedge clk);
      start1 = 1'b0;
      start4 = 1'b0;
      forever begin
         if (done_pend) begin
            check("done", o_done, 1);
            check("busy_at_done", o_busy, 0);
            if (start_on_done) begin
               start1 = !u4;
               start4 = u4;
               @(negedge clk);
               start1 = 1'b0;
               start4 = 1'b0;
               check("start_with_done", o_busy, 0);
            end
            break;
         end
         cyc++;
         if (cyc > 20000) begin
            check("timeout", nbytes, total);
            break;
         end
         check("in_ready", o_ready, (nacc < 256) && (mcnt <= bufw - zw));
         check("out_valid", o_valid, mcnt >= ow);
         if (stall_pend) check("stall_data", o_data, stall_data);

         start1 = 1'b0;
         start4 = 1'b0;
         gamma1_sel = sel;
         if (poke && cyc == 50) begin
            gamma1_sel = !sel;
            start1 = !u4;
            start4 = u4;
         end
         in_valid  = (nacc < 256) && ($urandom_range(0, 99) >= pct);
         in_coeff  = (nacc < 256) ? coeffs[nacc] : 32'h0;
         out_ready = ($urandom_range(0, 99) >= pct);

         if (o_valid && out_ready) begin
            w = '0;
            for (int k = 0; k < ob; k++)
               w[8*k +: 8] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("data", o_data, w);
            check("last", o_last, (nbytes + ob) == total);
            nbytes += ob;
            mcnt -= ow;
            if (nbytes >= total) done_pend = 1;
         end
         if (in_valid && o_ready) begin
            nacc++;
            mcnt += zw;
         end
         stall_pend = o_valid && !out_ready;
         stall_data = o_data;

         if (abort_at > 0 && nacc == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            check_idle_zero("after_reset");
            rst = 1'b0;
            exp_q.delete();
            break;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      start1    = 1'b0;
      start4    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start1 = 1'b0; start4 = 1'b0; gamma1_sel = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_coeff = '0; use4 = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset1");
      use4 = 1'b1;
      #0 check_idle_zero("reset4");
      rst = 1'b0;

      foreach (coeffs[i]) coeffs[i] = 32'h0;
      pattern_exp(72'h80_0008_0000, 5, 640);
      run_poly(0, 1, 0, 0, 0, 1);
      pattern_exp(72'h80_0020_0008_0002_0000, 9, 576);
      run_poly(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 256; i++)
         coeffs[i] = (i % 2 == 0) ? 32'd524288 : -32'sd524287;
      pattern_exp(72'hFF_FFF0_0000, 5, 640);
      run_poly(0, 1, 0, 0, 0, 0);

      rand_coeffs(0); model_exp(0); run_poly(0, 0, 30, 0, 0, 0);
      rand_coeffs(1); model_exp(1); run_poly(0, 1, 30, 0, 0, 0);

      rand_coeffs(1); model_exp(1); run_poly(0, 1, 30, 100, 0, 0);
      foreach (coeffs[i]) coeffs[i] = 32'h0;
      pattern_exp(72'h80_0020_0008_0002_0000, 9, 576);
      run_poly(0, 0, 0, 0, 1, 0);

      pattern_exp(72'h80_0008_0000, 5, 640);
      run_poly(1, 1, 0, 0, 0, 0);
      rand_coeffs(0); model_exp(0); run_poly(1, 0, 30, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
